turbo_encoder_pipe: RTL

TURBO_ENCODER_PIPE -- requirements
Module: turbo_encoder_pipe

---
 rtl/turbo_encoder_pipe_if.sv | 45 ++++
 rtl/turbo_encoder_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/turbo_encoder_pipe_if.sv
// Handshake and configuration bundle for turbo_encoder_pipe.
// The master side drives start/config, the input bit stream and out_ready.
// The slave side (the encoder) returns cfg_err, in_ready, busy and the output beats.
//
// Ports:
//   start, cfg_n, cfg_f1, cfg_f2 : block request and configuration (master -> slave)
//   cfg_err                      : rejected-start pulse (slave -> master)
//   in_valid/in_ready/in_bit     : input bit stream handshake
//   out_valid/out_ready          : output beat handshake
//   out_sys/out_p1/out_p2/out_x2 : output bits of a beat
//   out_tail/out_last            : termination-beat and final-beat flags
//   busy                         : encoder is not idle
interface turbo_encoder_pipe_if #(
    parameter int NW = 10
);
    logic          start;
    logic [NW-1:0] cfg_n;
    logic [NW-1:0] cfg_f1;
    logic [NW-1:0] cfg_f2;
    logic          cfg_err;
    logic          in_valid;
    logic          in_ready;
    logic          in_bit;
    logic          out_valid;
    logic          out_ready;
    logic          out_sys;
    logic          out_p1;
    logic          out_p2;
    logic          out_x2;
    logic          out_tail;
    logic          out_last;
    logic          busy;

    modport master (
        output start, cfg_n, cfg_f1, cfg_f2, in_valid, in_bit, out_ready,
        input  cfg_err, in_ready, out_valid, out_sys, out_p1, out_p2, out_x2,
               out_tail, out_last, busy
    );

    modport slave (
        input  start, cfg_n, cfg_f1, cfg_f2, in_valid, in_bit, out_ready,
        output cfg_err, in_ready, out_valid, out_sys, out_p1, out_p2, out_x2,
               out_tail, out_last, busy
    );
endinterface

// File: rtl/turbo_encoder_pipe.sv
// Purpose: rate-1/3 turbo encoder: buffers an N-bit block, then streams systematic,
//          RSC1 parity and QPP-interleaved RSC2 parity, followed by M joint tail beats.
// Latency: first data beat is valid 2 cycles after the N-th input bit is accepted.
// Backpressure: out_* are derived only from registers, so they hold while out_ready=0;
//               state, read address and interleaver index advance only on out_valid&out_ready.
//
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : slave modport of turbo_encoder_pipe_if (config, input stream, output beats)
module turbo_encoder_pipe #(
    parameter int         M       = 3,
    parameter int         MAX_N   = 512,
    parameter logic [M:0] FB_POLY = 4'b1101,
    parameter logic [M:0] FF_POLY = 4'b1011
) (
    input  logic                 clk,
    input  logic                 rst_n,
    turbo_encoder_pipe_if.slave  bus
);
    localparam int NW = $clog2(MAX_N + 1);
    localparam int AW = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ENC  = 2'd2;
    localparam logic [1:0] S_TAIL = 2'd3;

    // (a + b) mod n for a, b < n: one add, one conditional subtract.
    function automatic logic [NW-1:0] mod_add(input logic [NW-1:0] a,
                                              input logic [NW-1:0] b,
                                              input logic [NW-1:0] n);
        logic [NW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, n}) begin
            s = s - {1'b0, n};
        end
        return s[NW-1:0];
    endfunction

    logic [1:0]    r_state;
    logic [NW-1:0] r_n;
    logic [NW-1:0] r_f2x2;     // (2*f2) mod N, the constant step of g
    logic [NW-1:0] r_cnt;      // load count, data beat count, then tail beat count
    logic [NW-1:0] r_addr;     // natural index of the beat on the output
    logic [NW-1:0] r_pi;       // interleaved index of the beat on the output
    logic [NW-1:0] r_g;        // pi(i+1) - pi(i) mod N
    logic [M:1]    r_s1;
    logic [M:1]    r_s2;
    logic          r_vld;
    logic          r_rd_a;
    logic          r_rd_b;
    logic          r_cfg_err;
    logic          r_mem [0:(1<<AW)-1];

    logic          w_hs;
    logic          w_cfg_ok;
    logic          w_wr_en;
    logic          w_prime;
    logic          w_rd_en;
    logic [NW-1:0] w_rd_addr_a;
    logic [NW-1:0] w_rd_addr_b;
    logic [NW-1:0] w_pi_nxt;
    logic [NW-1:0] w_g_nxt;
    logic          w_last_data;
    logic          w_last_tail;
    logic          w_tail;
    logic          w_fb1;
    logic          w_fb2;
    logic          w_ff1;
    logic          w_ff2;
    logic          w_u1;
    logic          w_u2;
    logic          w_a1;
    logic          w_a2;
    logic          w_p1;
    logic          w_p2;

    assign w_hs     = r_vld & bus.out_ready;
    assign w_cfg_ok = (bus.cfg_n != '0) && (bus.cfg_n <= NW'(MAX_N)) &&
                      (bus.cfg_f1 < bus.cfg_n) && (bus.cfg_f2 < bus.cfg_n);
    assign w_wr_en  = (r_state == S_LOAD) & bus.in_valid;

    assign w_pi_nxt    = mod_add(r_pi, r_g, r_n);
    assign w_g_nxt     = mod_add(r_g, r_f2x2, r_n);
    assign w_last_data = (r_cnt == r_n - 1'b1);
    assign w_last_tail = (r_cnt == NW'(M - 1));
    assign w_tail      = (r_state == S_TAIL);

    // The first ENCODE cycle fetches beat 0 without a handshake; afterwards the
    // next beat is fetched on the handshake that retires the current one, so the
    // read data register always matches r_addr / r_pi.
    assign w_prime     = (r_state == S_ENC) & ~r_vld;
    assign w_rd_en     = w_prime | (w_hs & (r_state == S_ENC) & ~w_last_data);
    assign w_rd_addr_a = w_hs ? (r_addr + 1'b1) : r_addr;
    assign w_rd_addr_b = w_hs ? w_pi_nxt : r_pi;

    // RSC feedback and feed-forward taps over s[1..M]
    assign w_fb1 = ^(FB_POLY[M:1] & r_s1);
    assign w_fb2 = ^(FB_POLY[M:1] & r_s2);
    assign w_ff1 = ^(FF_POLY[M:1] & r_s1);
    assign w_ff2 = ^(FF_POLY[M:1] & r_s2);

    // Tail input equals the feedback, forcing a=0 so zeros shift in.
    assign w_u1 = w_tail ? w_fb1 : r_rd_a;
    assign w_u2 = w_tail ? w_fb2 : r_rd_b;
    assign w_a1 = w_u1 ^ w_fb1;
    assign w_a2 = w_u2 ^ w_fb2;
    assign w_p1 = (FF_POLY[0] & w_a1) ^ w_ff1;
    assign w_p2 = (FF_POLY[0] & w_a2) ^ w_ff2;

    assign bus.in_ready  = (r_state == S_LOAD);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.cfg_err   = r_cfg_err;
    assign bus.out_valid = r_vld;
    assign bus.out_sys   = r_vld & w_u1;
    assign bus.out_p1    = r_vld & w_p1;
    assign bus.out_p2    = r_vld & w_p2;
    assign bus.out_x2    = r_vld & w_tail & w_fb2;
    assign bus.out_tail  = r_vld & w_tail;
    assign bus.out_last  = r_vld & w_tail & w_last_tail;

    // Block buffer: one write port, two synchronous read ports; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_cnt[AW-1:0]] <= bus.in_bit;
        end
        if (w_rd_en) begin
            r_rd_a <= r_mem[w_rd_addr_a[AW-1:0]];
            r_rd_b <= r_mem[w_rd_addr_b[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_n       <= '0;
            r_f2x2    <= '0;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_pi      <= '0;
            r_g       <= '0;
            r_s1      <= '0;
            r_s2      <= '0;
            r_vld     <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_cfg_ok) begin
                            r_n     <= bus.cfg_n;
                            r_f2x2  <= mod_add(bus.cfg_f2, bus.cfg_f2, bus.cfg_n);
                            r_g     <= mod_add(bus.cfg_f1, bus.cfg_f2, bus.cfg_n);
                            r_cnt   <= '0;
                            r_state <= S_LOAD;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        if (r_cnt == r_n - 1'b1) begin
                            r_state <= S_ENC;
                            r_cnt   <= '0;
                            r_addr  <= '0;
                            r_pi    <= '0;
                            r_s1    <= '0;
                            r_s2    <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_ENC: begin
                    if (w_prime) begin
                        r_vld <= 1'b1;
                    end
                    if (w_hs) begin
                        r_s1   <= {r_s1[M-1:1], w_a1};
                        r_s2   <= {r_s2[M-1:1], w_a2};
                        r_addr <= r_addr + 1'b1;
                        r_pi   <= w_pi_nxt;
                        r_g    <= w_g_nxt;
                        if (w_last_data) begin
                            r_state <= S_TAIL;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_TAIL: begin
                    if (w_hs) begin
                        r_s1 <= {r_s1[M-1:1], w_a1};
                        r_s2 <= {r_s2[M-1:1], w_a2};
                        if (w_last_tail) begin
                            r_state <= S_IDLE;
                            r_vld   <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
